// File: rtl/cnna_pkg.sv
// Shared constants for the CNN accelerator datapath blocks: FSM encodings
// used by the sum RAM reader and the depth of its output FIFO.
package cnna_pkg;

    // Output FIFO depth; also the credit limit for outstanding reads.
    localparam int FIFO_DEPTH = 4;

    // Sum RAM reader FSM encodings.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/sum_ram_reader_if.sv
// Bus bundle for the sum RAM reader: control, RAM read port and output stream.
//
// Handshake: the output stream uses valid/ready. A word transfers on a rising
// clock edge where O_dv and I_ready are both high. Once O_dv rises it stays
// high, and O_dout stays constant, until that word transfers. I_ready may be
// driven independently of O_dv.
interface sum_ram_reader_if #(
    parameter int C_DSIZE = 24,
    parameter int C_OSIZE = 8,
    parameter int C_ASIZE = 10
);
    logic               I_start;
    logic [C_ASIZE:0]   I_len;
    logic [4:0]         I_shift;
    logic [C_ASIZE-1:0] O_raddr;
    logic               O_ren;
    logic [C_DSIZE-1:0] I_rdata;
    logic [C_OSIZE-1:0] O_dout;
    logic               O_dv;
    logic               I_ready;
    logic               O_busy;
    logic               O_done;
    logic [1:0]         O_state;

    // DUT side
    modport slave (
        input  I_start, I_len, I_shift, I_rdata, I_ready,
        output O_raddr, O_ren, O_dout, O_dv, O_busy, O_done, O_state
    );

    // Controller / RAM / consumer side
    modport master (
        output I_start, I_len, I_shift, I_rdata, I_ready,
        input  O_raddr, O_ren, O_dout, O_dv, O_busy, O_done, O_state
    );
endinterface

// File: rtl/sum_rd_fifo.sv
// 4-entry shifting FIFO. Entry 0 is the head, so the output is a register.
// Simultaneous push and pop keep occupancy unchanged, including when full.
module sum_rd_fifo #(
    parameter int C_W = 8
) (
    input  logic           I_clk,
    input  logic           I_rst,
    input  logic           I_push,
    input  logic [C_W-1:0] I_din,
    input  logic           I_pop,
    output logic [C_W-1:0] O_dout,
    output logic           O_empty,
    output logic [2:0]     O_count
);
    import cnna_pkg::*;

    logic [C_W-1:0] r_data [FIFO_DEPTH];
    logic [C_W-1:0] w_next [FIFO_DEPTH];
    logic [2:0]     r_cnt;
    logic [2:0]     w_cnt_n;
    logic           w_do_pop;
    logic           w_do_push;
    logic [1:0]     w_wr_idx;

    assign w_do_pop  = I_pop && (r_cnt != 3'd0);
    assign w_do_push = I_push && ((r_cnt != 3'(FIFO_DEPTH)) || w_do_pop);
    // When full and popping, cnt[1:0] is 0 and the subtraction wraps to 3.
    assign w_wr_idx  = r_cnt[1:0] - {1'b0, w_do_pop};

    assign O_dout  = r_data[0];
    assign O_empty = (r_cnt == 3'd0);
    assign O_count = r_cnt;

    // Next-state of the entry array: shift toward the head on pop, then write.
    always_comb begin
        w_next  = r_data;
        w_cnt_n = r_cnt;
        if (w_do_pop) begin
            for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
                w_next[i] = r_data[i+1];
            end
        end
        if (w_do_push) begin
            w_next[w_wr_idx] = I_din;
        end
        case ({w_do_push, w_do_pop})
            2'b10:   w_cnt_n = r_cnt + 3'd1;
            2'b01:   w_cnt_n = r_cnt - 3'd1;
            default: w_cnt_n = r_cnt;
        endcase
    end

    // Entry and occupancy registers.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_data[i] <= '0;
            end
            r_cnt <= 3'd0;
        end else begin
            r_data <= w_next;
            r_cnt  <= w_cnt_n;
        end
    end
endmodule

// File: rtl/sum_ram_reader.sv
// Drains accumulated sums from the sum RAM, shifts and saturates each one to
// the output width, and streams the result with a valid/ready handshake.
// Reads are credit-limited so returning data always has room in the FIFO.
module sum_ram_reader #(
    parameter int C_DSIZE = 24,
    parameter int C_OSIZE = 8,
    parameter int C_ASIZE = 10,
    parameter int C_RLAT  = 2
) (
    input logic              I_clk,
    input logic              I_rst,
    sum_ram_reader_if.slave  bus
);
    import cnna_pkg::*;

    localparam logic [C_ASIZE:0]   L_ONE_LEN  = 1;
    localparam logic [C_ASIZE-1:0] L_ONE_ADDR = 1;
    localparam logic signed [C_DSIZE-1:0] L_MAX =
        {{(C_DSIZE-C_OSIZE+1){1'b0}}, {(C_OSIZE-1){1'b1}}};
    localparam logic signed [C_DSIZE-1:0] L_MIN =
        {{(C_DSIZE-C_OSIZE+1){1'b1}}, {(C_OSIZE-1){1'b0}}};

    logic [1:0]          r_state;
    logic [C_ASIZE:0]    r_len;
    logic [4:0]          r_shift;
    logic [C_ASIZE-1:0]  r_addr;
    logic [C_RLAT-1:0]   r_vsr;
    logic [2:0]          r_infl;

    logic [2:0]          w_fifo_cnt;
    logic                w_fifo_empty;
    logic [C_OSIZE-1:0]  w_fifo_dout;
    logic                w_credit;
    logic                w_ren;
    logic                w_last;
    logic                w_ret;
    logic                w_pop;
    logic signed [C_DSIZE-1:0] w_sh;
    logic [C_OSIZE-1:0]  w_sat;

    // Outstanding reads plus buffered words must stay below the FIFO depth.
    assign w_credit = ({1'b0, r_infl} + {1'b0, w_fifo_cnt}) < 4'(FIFO_DEPTH);
    assign w_ren    = (r_state == ST_READ) && w_credit;
    assign w_last   = ({1'b0, r_addr} == (r_len - L_ONE_LEN));
    assign w_ret    = r_vsr[C_RLAT-1];
    assign w_pop    = !w_fifo_empty && bus.I_ready;

    // Arithmetic shift floors toward negative infinity; then clamp.
    assign w_sh  = $signed(bus.I_rdata) >>> r_shift;
    assign w_sat = (w_sh > L_MAX) ? L_MAX[C_OSIZE-1:0] :
                   (w_sh < L_MIN) ? L_MIN[C_OSIZE-1:0] : w_sh[C_OSIZE-1:0];

    assign bus.O_raddr = r_addr;
    assign bus.O_ren   = w_ren;
    assign bus.O_dout  = w_fifo_dout;
    assign bus.O_dv    = !w_fifo_empty;
    assign bus.O_busy  = (r_state != ST_IDLE);
    assign bus.O_done  = (r_state == ST_DONE);
    assign bus.O_state = r_state;

    // Control FSM: latch the job, issue addresses, wait for the pipe to empty.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_state <= ST_IDLE;
            r_len   <= '0;
            r_shift <= '0;
            r_addr  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.I_start) begin
                        r_len   <= bus.I_len;
                        r_shift <= bus.I_shift;
                        r_addr  <= '0;
                        r_state <= (bus.I_len == '0) ? ST_DONE : ST_READ;
                    end
                end
                ST_READ: begin
                    if (w_ren) begin
                        if (w_last) r_state <= ST_DRAIN;
                        else        r_addr  <= r_addr + L_ONE_ADDR;
                    end
                end
                ST_DRAIN: begin
                    if ((r_infl == 3'd0) && w_fifo_empty) r_state <= ST_DONE;
                end
                ST_DONE:  r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    // Read-valid pipeline aligned with the RAM latency, plus in-flight count.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_vsr  <= '0;
            r_infl <= 3'd0;
        end else begin
            r_vsr[0] <= w_ren;
            for (int i = 1; i < C_RLAT; i++) begin
                r_vsr[i] <= r_vsr[i-1];
            end
            case ({w_ren, w_ret})
                2'b10:   r_infl <= r_infl + 3'd1;
                2'b01:   r_infl <= r_infl - 3'd1;
                default: r_infl <= r_infl;
            endcase
        end
    end

    sum_rd_fifo #(.C_W(C_OSIZE)) u_fifo (
        .I_clk   (I_clk),
        .I_rst   (I_rst),
        .I_push  (w_ret),
        .I_din   (w_sat),
        .I_pop   (w_pop),
        .O_dout  (w_fifo_dout),
        .O_empty (w_fifo_empty),
        .O_count (w_fifo_cnt)
    );
endmodule

// File: tb/tb_sum_ram_reader.sv
// Bench for sum_ram_reader: RAM model with fixed read latency, a scoreboard
// of expected output words, and directed drains covering order, saturation,
// back-pressure, empty jobs, mid-drain reset and a full-size drain.
module tb_sum_ram_reader;
  import cnna_pkg::*;

  localparam int DS = 24;
  localparam int OS = 8;
  localparam int AS = 10;
  localparam int RL = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sum_ram_reader_if #(.C_DSIZE(DS), .C_OSIZE(OS), .C_ASIZE(AS)) bus();

  sum_ram_reader #(.C_DSIZE(DS), .C_OSIZE(OS), .C_ASIZE(AS), .C_RLAT(RL)) dut (
    .I_clk (clk),
    .I_rst (rst),
    .bus   (bus)
  );

  // ---------------- RAM model: data valid RL cycles after the read ----------------
  logic [DS-1:0] mem [0:(1<<AS)-1];
  logic [DS-1:0] ram_p1;
  always @(posedge clk) begin
    ram_p1      <= mem[bus.O_raddr];
    bus.I_rdata <= ram_p1;
  end

  // ---------------- scoreboard state ----------------
  logic [OS-1:0] exp_q[$];
  int tests = 0;
  int fails = 0;
  int cyc, first_dv, last_dv, done_cnt, done_cyc, issued, xfer, dv_cnt;
  logic [AS-1:0] rd_idx;

  function automatic logic [OS-1:0] model(logic [DS-1:0] raw, int sh);
    longint x, d, q, hi, lo;
    x  = longint'($signed(raw));
    d  = longint'(1) << sh;
    q  = x / d;
    if ((x % d) != 0 && x < 0) q = q - 1;
    hi = (longint'(1) << (OS - 1)) - 1;
    lo = -(longint'(1) << (OS - 1));
    if (q > hi) q = hi;
    if (q < lo) q = lo;
    return q[OS-1:0];
  endfunction

  function automatic logic ready_of(int mode, int c);
    case (mode)
      0:       return 1'b1;
      1:       return (c % 3) == 0;
      2:       return (c % 2) == 0;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic chk(string tag, logic signed [31:0] got, logic signed [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_counters();
    cyc = 0; first_dv = -1; last_dv = -1; done_cnt = 0; done_cyc = -1;
    issued = 0; xfer = 0; dv_cnt = 0; rd_idx = '0;
  endtask

  // One clock: monitor at the falling edge, return 1 time unit after rising edge.
  task automatic tick();
    @(negedge clk);
    if (!rst) begin
      if (bus.O_done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (bus.O_ren) begin
        chk("credit", 32'(issued - xfer < 4), 1);
        chk("raddr", 32'(bus.O_raddr), 32'(rd_idx));
        issued++;
        rd_idx++;
      end
      if (bus.O_dv) begin
        dv_cnt++;
        if (first_dv < 0) first_dv = cyc;
        last_dv = cyc;
      end
      if (bus.O_dv && bus.I_ready) begin
        if (exp_q.size() == 0) chk("extra_word", 1, 0);
        else chk("dout", $signed(bus.O_dout), $signed(exp_q.pop_front()));
        xfer++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // ---------------- driver: one complete drain ----------------
  task automatic run_drain(string tag, int len, int sh, int mode, int spike);
    int budget;
    for (int i = 0; i < len; i++) exp_q.push_back(model(mem[i], sh));
    clear_counters();
    budget        = len * 4 + 40;
    bus.I_len     = len[AS:0];
    bus.I_shift   = sh[4:0];
    bus.I_start   = 1'b1;
    while (done_cnt == 0 && cyc < budget) begin
      bus.I_ready = ready_of(mode, cyc);
      tick();
      bus.I_start = (spike > 0) && (cyc == spike);
      if (bus.I_start) bus.I_len = 11'd5;
      if (cyc == 1 && len > 0) chk({tag, "_busy"}, 32'(bus.O_busy), 1);
    end
    bus.I_start = 1'b0;
    chk({tag, "_done_seen"}, 32'(done_cnt > 0), 1);
    bus.I_ready = 1'b1;
    repeat (3) tick();
    chk({tag, "_done_once"}, done_cnt, 1);
    chk({tag, "_words"}, xfer, len);
    chk({tag, "_q_empty"}, exp_q.size(), 0);
    chk({tag, "_busy_end"}, 32'(bus.O_busy), 0);
    if (mode == 0 && len > 0) begin
      chk({tag, "_first_dv"}, first_dv, RL + 2);
      chk({tag, "_back2back"}, last_dv - first_dv, len - 1);
    end
    if (len == 0) begin
      chk({tag, "_done_cyc"}, done_cyc, 1);
      chk({tag, "_no_ren"}, issued, 0);
      chk({tag, "_no_dv"}, dv_cnt, 0);
    end
    exp_q.delete();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst         = 1'b1;
    bus.I_start = 1'b0;
    bus.I_len   = '0;
    bus.I_shift = '0;
    bus.I_ready = 1'b0;
    for (int i = 0; i < (1 << AS); i++) mem[i] = DS'(i);
    clear_counters();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ren",   32'(bus.O_ren), 0);
    chk("rst_raddr", 32'(bus.O_raddr), 0);
    chk("rst_dv",    32'(bus.O_dv), 0);
    chk("rst_dout",  32'(bus.O_dout), 0);
    chk("rst_busy",  32'(bus.O_busy), 0);
    chk("rst_done",  32'(bus.O_done), 0);
    chk("rst_state", 32'(bus.O_state), 32'(ST_IDLE));
    rst = 1'b0;
    tick();

    // Sequential data, full throughput.
    run_drain("seq8", 8, 0, 0, 0);

    // Saturation and floor rounding.
    mem[0] = DS'(1000);
    run_drain("sat_pos", 1, 2, 0, 0);
    mem[0] = DS'(-1000);
    run_drain("sat_neg", 1, 2, 0, 0);
    mem[0] = DS'(-5);
    run_drain("floor", 1, 1, 0, 0);

    // Random sums with random back-pressure.
    for (int i = 0; i < 32; i++) mem[i] = DS'($urandom);
    run_drain("rand32", 32, 16, 3, 0);
    for (int i = 0; i < 32; i++) mem[i] = DS'(i);

    // Sparse ready: exercises the credit limit.
    run_drain("credit16", 16, 0, 1, 0);

    // Empty job.
    run_drain("len0", 0, 0, 0, 0);

    // Start pulse while reading must be ignored.
    run_drain("spike", 16, 0, 2, 3);

    // Reset after five words of sixteen.
    for (int i = 0; i < 16; i++) exp_q.push_back(model(mem[i], 0));
    clear_counters();
    bus.I_len   = 11'd16;
    bus.I_shift = 5'd0;
    bus.I_ready = 1'b1;
    bus.I_start = 1'b1;
    while (xfer < 5 && cyc < 200) begin
      tick();
      bus.I_start = 1'b0;
    end
    rst = 1'b1;
    tick();
    chk("mid_rst_ren",   32'(bus.O_ren), 0);
    chk("mid_rst_raddr", 32'(bus.O_raddr), 0);
    chk("mid_rst_dv",    32'(bus.O_dv), 0);
    chk("mid_rst_dout",  32'(bus.O_dout), 0);
    chk("mid_rst_busy",  32'(bus.O_busy), 0);
    chk("mid_rst_done",  32'(bus.O_done), 0);
    rst = 1'b0;
    exp_q.delete();
    done_cnt = 0;
    dv_cnt   = 0;
    repeat (6) tick();
    chk("post_rst_no_dv",   dv_cnt, 0);
    chk("post_rst_no_done", done_cnt, 0);
    run_drain("after_rst", 8, 1, 0, 0);

    // Full address range, every address exactly once.
    for (int i = 0; i < (1 << AS); i++) mem[i] = DS'($urandom);
    run_drain("full", 1 << AS, 16, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sum_ram_reader.md
SUM_RAM_READER -- requirements
Module: sum_ram_reader

Interface
REQ-001 SHALL have parameter C_DSIZE, default 24, accumulated sum width read from the sum RAM (signed).
REQ-002 SHALL have parameter C_OSIZE, default 8, output word width (signed).
REQ-003 SHALL have parameter C_ASIZE, default 10, sum RAM address width.
REQ-004 SHALL have parameter C_RLAT, default 2, sum RAM read latency in cycles from O_raddr to I_rdata.
REQ-005 SHALL have port I_clk, input, 1, sole clock.
REQ-006 SHALL have port I_rst, input, 1, reset; synchronous, active-high.
REQ-007 SHALL have port I_start, input, 1, one-cycle pulse that starts a drain.
REQ-008 SHALL have port I_len, input, C_ASIZE+1, number of words to read (0..2^C_ASIZE).
REQ-009 SHALL have port I_shift, input, 5, right-shift amount applied to each sum.
REQ-010 SHALL have port O_raddr, output, C_ASIZE, sum RAM read address.
REQ-011 SHALL have port O_ren, output, 1, sum RAM read enable.
REQ-012 SHALL have port I_rdata, input, C_DSIZE, sum RAM read data, valid C_RLAT cycles after O_ren.
REQ-013 SHALL have port O_dout, output, C_OSIZE, output word.
REQ-014 SHALL have port O_dv, output, 1, O_dout valid.
REQ-015 SHALL have port I_ready, input, 1, downstream accept; transfer occurs when O_dv and I_ready are both high.
REQ-016 SHALL have port O_busy, output, 1, high from the accepted I_start until O_done.
REQ-017 SHALL have port O_done, output, 1, one-cycle pulse after the last word is transferred.

Function
REQ-018 SHALL use FSM states IDLE, READ, DRAIN, DONE.
REQ-019 In IDLE, I_start SHALL latch I_len and I_shift, clear the address to 0, and enter READ, or enter DONE directly when I_len=0.
REQ-020 I_start outside IDLE SHALL be ignored.
REQ-021 In READ, O_ren SHALL assert with O_raddr incrementing by 1 per issued read, but only while in-flight reads plus FIFO occupancy is below 4 (credit rule).
REQ-022 After address I_len-1 is issued, the FSM SHALL enter DRAIN.
REQ-023 DRAIN->DONE SHALL occur when in-flight count = 0 and the FIFO is empty.
REQ-024 DONE SHALL assert O_done for one cycle, then return to IDLE.
REQ-025 Returned I_rdata SHALL be tracked by a C_RLAT-deep valid shift register and written to a 4-entry output FIFO; the FIFO SHALL never overflow.
REQ-026 The data path SHALL compute O_dout = signed saturation to C_OSIZE of (I_rdata arithmetic-shifted right by the latched shift), truncating toward negative infinity; the clamp range is [-2^(C_OSIZE-1), 2^(C_OSIZE-1)-1].
REQ-027 Output order SHALL equal address order; no word is dropped or duplicated under any I_ready pattern.
REQ-028 O_dv SHALL be high exactly when the FIFO is non-empty; O_dout SHALL be stable while O_dv=1 and I_ready=0.
REQ-029 A FIFO push and pop in the same cycle SHALL leave occupancy unchanged, including when full.
REQ-030 With I_ready held at 1, throughput SHALL be 1 word/cycle; first O_dv SHALL occur C_RLAT+2 cycles after I_start.
REQ-031 I_len=2^C_ASIZE SHALL read every address once; the address SHALL not wrap within a drain.

Reset
REQ-032 I_rst SHALL force: state IDLE, O_ren=0, O_raddr=0, O_dv=0, O_dout=0, O_busy=0, O_done=0, FIFO empty, in-flight count 0, valid shift register cleared.
REQ-033 Reset mid-drain SHALL abort without an O_done pulse; data returning after reset SHALL be discarded.

Structure
REQ-034 FSM state encodings and the FIFO depth constant (4) SHALL reside in the shared cnna package.
REQ-035 The output FIFO SHALL be one sub-module, sum_rd_fifo (4 entries, width C_OSIZE, registered output).

Verification
REQ-036 I_len=8, shift=0, I_ready=1, RAM[i]=i -> O_dout 0..7 on consecutive cycles, O_done exactly once.
REQ-037 RAM=1000 at shift=2 -> 127; RAM=-1000 at shift=2 -> -128; RAM=-5 at shift=1 -> -3.
REQ-038 I_len=16 with I_ready toggling 1-of-3 -> all 16 words in order, O_ren never high while credit = 0.
REQ-039 I_len=0 -> O_done 1 cycle after I_start, no O_ren, no O_dv.
REQ-040 I_rst at word 5 of 16 -> all outputs 0 the next cycle, no O_done; a new I_start completes normally.
REQ-041 I_start pulsed during READ -> ignored; word count is unchanged.
